ldpc_dvb_enc_mux_buf: RTL

Next-generation encoder output muxer for the DVB-S2 LDPC encoder engine. It merges systematic data column words and accumulated parity words into one column-addressed write stream. Compared with the current muxer it adds parametrised widths, runtime-selectable parity chaining, a frame-tracking FSM with protocol error detection, and an output FIFO with downstream backpressure. It sits between the encoder engine and the codeword output buffer.

---
 rtl/ldpc_dvb_enc_mux_buf_pkg.sv | 23 ++
 rtl/ldpc_dvb_enc_mux_fifo.sv | 64 ++++++
 rtl/ldpc_dvb_enc_mux_buf.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ldpc_dvb_enc_mux_buf_pkg.sv
// Shared types for the DVB-S2 LDPC encoder output muxer: default widths,
// column/word types, parity strobes and frame-tracking FSM states.
package ldpc_dvb_enc_mux_buf_pkg;

   localparam int cZDAT_W    = 360;
   localparam int cCOL_W     = 8;
   localparam int cBUF_DEPTH = 4;

   typedef logic [cZDAT_W-1:0] zdat_t;
   typedef logic [cCOL_W-1:0]  col_t;

   typedef struct packed {
      logic sof;
      logic eof;
   } strb_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

endpackage

// File: rtl/ldpc_dvb_enc_mux_fifo.sv
// Show-ahead register FIFO: head word is visible on odat while not empty.
// oafull is registered from the next-cycle fill level so it is exact each cycle.
module ldpc_dvb_enc_mux_fifo #(
   parameter int pDAT_W = 8,
   parameter int pDEPTH = 4,
   parameter int pAFULL = 2
) (
   input  logic              iclk,
   input  logic              ireset,
   input  logic              iclkena,
   input  logic              ipush,
   input  logic              ipop,
   input  logic [pDAT_W-1:0] idat,
   output logic [pDAT_W-1:0] odat,
   output logic              ofull,
   output logic              oempty,
   output logic              oafull
);

   localparam int          cAW    = $clog2(pDEPTH);
   localparam logic [cAW:0] cDEPTH = (cAW+1)'(pDEPTH);
   localparam logic [cAW:0] cAFULL = (cAW+1)'(pAFULL);

   logic [pDAT_W-1:0] mem [pDEPTH];
   logic [cAW-1:0]    wptr, rptr;
   logic [cAW:0]      used, used_nxt;
   logic              do_push, do_pop;

   assign ofull   = (used == cDEPTH);
   assign oempty  = (used == '0);
   assign do_pop  = iclkena & ipop & !oempty;
   // a full FIFO still accepts a word when the head leaves in the same cycle
   assign do_push = iclkena & ipush & (!ofull | do_pop);

   always_comb begin
      used_nxt = used;
      if (do_push & !do_pop)
         used_nxt = used + 1'b1;
      else if (!do_push & do_pop)
         used_nxt = used - 1'b1;
   end

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         wptr   <= '0;
         rptr   <= '0;
         used   <= '0;
         oafull <= 1'b0;
      end else if (iclkena) begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         used   <= used_nxt;
         oafull <= (used_nxt >= cAFULL);
      end
   end

   always_ff @(posedge iclk) begin
      if (do_push)
         mem[wptr] <= idat;
   end

   assign odat = mem[rptr];

endmodule

// File: rtl/ldpc_dvb_enc_mux_buf.sv
// Encoder output muxer: merges data column words and (optionally chained)
// parity words into one column-addressed write stream through an output FIFO.
module ldpc_dvb_enc_mux_buf
   import ldpc_dvb_enc_mux_buf_pkg::*;
#(
   parameter int pZDAT_W    = cZDAT_W,
   parameter int pCOL_W     = cCOL_W,
   parameter int pBUF_DEPTH = cBUF_DEPTH
) (
   input  logic               iclk,
   input  logic               ireset,
   input  logic               iclkena,
   input  logic [pCOL_W-1:0]  iused_data_col,
   input  logic               ichain_ena,
   input  logic               ival,
   input  logic [pCOL_W-1:0]  icol,
   input  logic [pZDAT_W-1:0] idat,
   input  logic               ipval,
   input  logic               ipsof,
   input  logic               ipeof,
   input  logic [pZDAT_W-1:0] ipacc,
   input  logic [pZDAT_W-1:0] ipline,
   input  logic               iwrdy,
   output logic               owbusy,
   output logic               owrite,
   output logic [pCOL_W-1:0]  owaddr,
   output logic [pZDAT_W-1:0] owdat,
   output logic               owfull,
   output logic               oerr
);

   localparam int cENT_W = 1 + pCOL_W + pZDAT_W;

   state_t               state, state_nxt;
   strb_t                pstrb;
   logic                 vld_s1, eof_s1, head_eof;
   logic [pCOL_W-1:0]    addr_s1, p_addr, last_addr;
   logic [pZDAT_W-1:0]   dat_s1, p_dat, last_dat;
   logic [cENT_W-1:0]    head;
   logic                 fifo_empty, fifo_full, fifo_afull;
   logic                 perr, ovf;

   assign pstrb  = '{sof: ipsof, eof: ipeof};

   // sof restarts the chain from the line seed; otherwise chain or reseed per word
   assign p_addr = pstrb.sof ? iused_data_col : last_addr + pCOL_W'(1);
   assign p_dat  = ipacc ^ ((pstrb.sof | !ichain_ena) ? ipline : last_dat);

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         vld_s1    <= 1'b0;
         addr_s1   <= '0;
         dat_s1    <= '0;
         eof_s1    <= 1'b0;
         last_addr <= '0;
         last_dat  <= '0;
      end else if (iclkena) begin
         vld_s1 <= ival | ipval;
         if (ipval) begin
            addr_s1   <= p_addr;
            dat_s1    <= p_dat;
            eof_s1    <= pstrb.eof;
            last_addr <= p_addr;
            last_dat  <= p_dat;
         end else if (ival) begin
            addr_s1 <= icol;
            dat_s1  <= idat;
            eof_s1  <= 1'b0;
         end
      end
   end

   ldpc_dvb_enc_mux_fifo #(
      .pDAT_W (cENT_W),
      .pDEPTH (pBUF_DEPTH),
      .pAFULL (pBUF_DEPTH-2)
   ) u_fifo (
      .iclk    (iclk),
      .ireset  (ireset),
      .iclkena (iclkena),
      .ipush   (vld_s1),
      .ipop    (owrite),
      .idat    ({eof_s1, addr_s1, dat_s1}),
      .odat    (head),
      .ofull   (fifo_full),
      .oempty  (fifo_empty),
      .oafull  (fifo_afull)
   );

   assign owrite = !fifo_empty & iwrdy & iclkena;
   assign {head_eof, owaddr, owdat} = head;
   assign owfull = owrite & head_eof;
   assign owbusy = fifo_afull;
   assign ovf    = iclkena & vld_s1 & fifo_full & !owrite;

   always_comb begin
      state_nxt = state;
      perr      = ival & ipval;
      case (state)
         ST_IDLE, ST_DATA: begin
            if (ipval) begin
               if (pstrb.sof)
                  state_nxt = pstrb.eof ? ST_IDLE : ST_PARITY;
               else
                  perr = 1'b1;
            end else if (ival) begin
               state_nxt = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (ival) perr = 1'b1;
            if (ipval) begin
               if (pstrb.sof) perr = 1'b1;
               if (pstrb.eof) state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         state <= ST_IDLE;
         oerr  <= 1'b0;
      end else if (iclkena) begin
         state <= state_nxt;
         oerr  <= oerr | perr | ovf;
      end
   end

endmodule
